digit_scan_ctrl: RTL and testbench

- Scan controller that drives the select and data inputs of the 1-to-4 nibble demultiplexer feeding the four display digits.
- Holds a 16-bit display value in a shadow register and steps through digits 0..3, dwelling DWELL clocks on each one.
- Accepts new values at any time but commits them only at a frame boundary, so a frame never shows a mix of old and new digits.

---
 rtl/digit_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: scan controller for a four-digit display fed through a
// 1-to-4 nibble demultiplexer. Holds a 16-bit display value in a shadow
// register and steps through digits 0..3, dwelling DWELL clocks on each.
// New values are accepted at any time into a pending register and are
// committed to the shadow register only at a frame boundary (or on scan
// entry), so a frame never mixes old and new digits.
//
// Optional feature: define DIGIT_SCAN_LZ_BLANK_EN to enable leading-zero
// blanking (digit_valid_o low for digits k>0 whose nibbles k..3 are all zero).
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   enable_i       1 = scanning, 0 = idle
//   load_i         single-cycle strobe, captures value_i into pending
//   value_i[15:0]  display value, digit k = value_i[4k+3:4k]
//   sel_o[1:0]     digit select to the demux
//   nibble_o[3:0]  data for the selected digit
//   digit_valid_o  selected digit should be lit
//   frame_done_o   one-cycle pulse when digit 3's dwell ends
//   load_ack_o     one-cycle pulse when a pending value is committed

module digit_scan_ctrl #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    output logic [1:0]  sel_o,
    output logic [3:0]  nibble_o,
    output logic        digit_valid_o,
    output logic        frame_done_o,
    output logic        load_ack_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_q, pend_d;
    logic [3:0]       nibble_q, nibble_d;
    logic             valid_q, valid_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ack_q, load_ack_d;
    logic             commit_slot;

    // Next-state: FSM, dwell counter, load/commit path.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        load_ack_d   = 1'b0;
        commit_slot  = 1'b0;

        if (load_i) begin
            pending_d = value_i;
            pend_d    = 1'b1;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                sel_d = 2'd0;
                if (enable_i) begin
                    state_d     = StScan;
                    commit_slot = 1'b1;
                end
            end
            StScan: begin
                // Dropping enable beats the frame boundary: no commit, no frame_done.
                if (!enable_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end else if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    sel_d = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        commit_slot  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A load arriving in the commit cycle goes straight to shadow.
        if (commit_slot && (pend_q || load_i)) begin
            shadow_d   = load_i ? value_i : pending_q;
            pend_d     = 1'b0;
            load_ack_d = 1'b1;
        end
    end

    // Registered outputs are computed from next-state so sel, nibble and
    // digit_valid all move on the same edge.
    always_comb begin
        nibble_d = 4'd0;
        valid_d  = 1'b0;
        if (state_d == StScan) begin
            case (sel_d)
                2'd0:    nibble_d = shadow_d[3:0];
                2'd1:    nibble_d = shadow_d[7:4];
                2'd2:    nibble_d = shadow_d[11:8];
                default: nibble_d = shadow_d[15:12];
            endcase
`ifdef DIGIT_SCAN_LZ_BLANK_EN
            case (sel_d)
                2'd0:    valid_d = 1'b1;
                2'd1:    valid_d = |shadow_d[15:4];
                2'd2:    valid_d = |shadow_d[15:8];
                default: valid_d = |shadow_d[15:12];
            endcase
`else
            valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            shadow_q     <= 16'd0;
            pending_q    <= 16'd0;
            pend_q       <= 1'b0;
            nibble_q     <= 4'd0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            nibble_q     <= nibble_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign sel_o         = sel_q;
    assign nibble_o      = nibble_q;
    assign digit_valid_o = valid_q;
    assign frame_done_o  = frame_done_q;
    assign load_ack_o    = load_ack_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Testbench for digit_scan_ctrl with DWELL=4 (16-clock frames).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_digit_scan_ctrl;

    localparam int unsigned DWELL = 4;
    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [1:0]  sel;
    logic [3:0]  nibble;
    logic        digit_valid;
    logic        frame_done;
    logic        load_ack;

    int errors = 0;
    int checks = 0;
    int pos    = 0;   // clocks since the current scan entry

    digit_scan_ctrl #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .load_i        (load),
        .value_i       (value),
        .sel_o         (sel),
        .nibble_o      (nibble),
        .digit_valid_o (digit_valid),
        .frame_done_o  (frame_done),
        .load_ack_o    (load_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dig(input logic [15:0] sh, input int s);
        return sh[4*s +: 4];
    endfunction

    function automatic logic exp_valid(input logic [15:0] sh, input int s);
`ifdef DIGIT_SCAN_LZ_BLANK_EN
        logic [15:0] hi;
        if (s == 0) return 1'b1;
        hi = sh >> (4 * s);
        return hi != 16'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; load = 1'b1; value = 16'hFFFF;
        tick(); tick();
        checks += 5;
        if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        if (nibble !== 4'd0) begin errors++; $display("FAIL reset_nibble got=%h exp=0", nibble); end
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", digit_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
        rst_n = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (sel !== 2'd0) begin errors++; $display("FAIL idle_sel got=%0d exp=0", sel); end
            if (digit_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", digit_valid); end
            if (load_ack !== 1'b0) begin errors++; $display("FAIL idle_ack got=%b exp=0", load_ack); end
        end
    endtask

    task automatic test_basic_scan();
        logic [15:0] sh = 16'h1234;
        load = 1'b1; value = sh; tick();
        load = 1'b0; enable = 1'b1; tick();
        pos = 0;
        checks += 4;
        if (load_ack !== 1'b1) begin errors++; $display("FAIL entry_ack got=%b exp=1", load_ack); end
        if (sel !== 2'd0) begin errors++; $display("FAIL entry_sel got=%0d exp=0", sel); end
        if (nibble !== 4'h4) begin errors++; $display("FAIL entry_nibble got=%h exp=4", nibble); end
        if (digit_valid !== 1'b1) begin errors++; $display("FAIL entry_valid got=%b exp=1", digit_valid); end
        for (int c = 1; c <= 16; c++) begin
            tick(); pos++;
            checks += 5;
            if (sel !== 2'((pos / 4) % 4)) begin errors++; $display("FAIL basic_sel p=%0d got=%0d exp=%0d", pos, sel, (pos / 4) % 4); end
            if (nibble !== dig(sh, (pos / 4) % 4)) begin errors++; $display("FAIL basic_nibble p=%0d got=%h exp=%h", pos, nibble, dig(sh, (pos / 4) % 4)); end
            if (digit_valid !== 1'b1) begin errors++; $display("FAIL basic_valid p=%0d got=%b exp=1", pos, digit_valid); end
            if (frame_done !== (pos == 16)) begin errors++; $display("FAIL basic_fd p=%0d got=%b exp=%b", pos, frame_done, pos == 16); end
            if (load_ack !== 1'b0) begin errors++; $display("FAIL basic_ack p=%0d got=%b exp=0", pos, load_ack); end
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] sh;
        while (pos < 20) begin tick(); pos++; end
        load = 1'b1; value = 16'hABCD; tick(); pos++;
        value = 16'h9876; tick(); pos++;
        load = 1'b0; value = 16'h0000;
        while (pos < 48) begin
            tick(); pos++;
            sh = (pos >= 32) ? 16'h9876 : 16'h1234;
            checks += 4;
            if (sel !== 2'((pos / 4) % 4)) begin errors++; $display("FAIL tear_sel p=%0d got=%0d exp=%0d", pos, sel, (pos / 4) % 4); end
            if (nibble !== dig(sh, (pos / 4) % 4)) begin errors++; $display("FAIL tear_nibble p=%0d got=%h exp=%h", pos, nibble, dig(sh, (pos / 4) % 4)); end
            if (load_ack !== (pos == 32)) begin errors++; $display("FAIL tear_ack p=%0d got=%b exp=%b", pos, load_ack, pos == 32); end
            if (frame_done !== (pos % 16 == 0)) begin errors++; $display("FAIL tear_fd p=%0d got=%b exp=%b", pos, frame_done, pos % 16 == 0); end
        end
    endtask

    task automatic test_boundary_collision();
        logic [15:0] sh;
        while (pos < 50) begin tick(); pos++; end
        load = 1'b1; value = 16'h1111; tick(); pos++;
        load = 1'b0;
        while (pos < 63) begin tick(); pos++; end
        // Wrap edge: pending 1111 is overridden by the incoming 2222.
        load = 1'b1; value = 16'h2222; tick(); pos++;
        load = 1'b0; value = 16'h0000;
        checks += 3;
        if (load_ack !== 1'b1) begin errors++; $display("FAIL coll_ack got=%b exp=1", load_ack); end
        if (frame_done !== 1'b1) begin errors++; $display("FAIL coll_fd got=%b exp=1", frame_done); end
        if (nibble !== 4'h2) begin errors++; $display("FAIL coll_nibble got=%h exp=2", nibble); end
        while (pos < 80) begin
            tick(); pos++;
            sh = 16'h2222;
            checks += 3;
            if (nibble !== dig(sh, (pos / 4) % 4)) begin errors++; $display("FAIL coll_nibble p=%0d got=%h exp=%h", pos, nibble, dig(sh, (pos / 4) % 4)); end
            if (load_ack !== 1'b0) begin errors++; $display("FAIL coll_ack p=%0d got=%b exp=0", pos, load_ack); end
            if (frame_done !== (pos == 80)) begin errors++; $display("FAIL coll_fd p=%0d got=%b exp=%b", pos, frame_done, pos == 80); end
        end
    endtask

    task automatic test_enable_drop();
        logic [15:0] sh = 16'h5678;
        while (pos < 85) begin tick(); pos++; end
        load = 1'b1; value = sh; tick(); pos++;
        load = 1'b0;
        while (pos < 89) begin tick(); pos++; end
        // Now sel=2, count=1.
        enable = 1'b0; tick();
        checks += 5;
        if (sel !== 2'd0) begin errors++; $display("FAIL drop_sel got=%0d exp=0", sel); end
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got=%b exp=0", digit_valid); end
        if (nibble !== 4'd0) begin errors++; $display("FAIL drop_nibble got=%h exp=0", nibble); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL drop_fd got=%b exp=0", frame_done); end
        if (load_ack !== 1'b0) begin errors++; $display("FAIL drop_ack got=%b exp=0", load_ack); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (frame_done !== 1'b0) begin errors++; $display("FAIL drop_idle_fd got=%b exp=0", frame_done); end
            if (digit_valid !== 1'b0) begin errors++; $display("FAIL drop_idle_valid got=%b exp=0", digit_valid); end
        end
        enable = 1'b1; tick(); pos = 0;
        checks += 3;
        if (load_ack !== 1'b1) begin errors++; $display("FAIL reentry_ack got=%b exp=1", load_ack); end
        if (sel !== 2'd0) begin errors++; $display("FAIL reentry_sel got=%0d exp=0", sel); end
        if (nibble !== 4'h8) begin errors++; $display("FAIL reentry_nibble got=%h exp=8", nibble); end
        while (pos < 31) begin
            if (pos == 20) begin load = 1'b1; value = 16'h0050; end
            else load = 1'b0;
            tick(); pos++;
            checks += 3;
            if (sel !== 2'((pos / 4) % 4)) begin errors++; $display("FAIL restart_sel p=%0d got=%0d exp=%0d", pos, sel, (pos / 4) % 4); end
            if (nibble !== dig(sh, (pos / 4) % 4)) begin errors++; $display("FAIL restart_nibble p=%0d got=%h exp=%h", pos, nibble, dig(sh, (pos / 4) % 4)); end
            if (frame_done !== (pos == 16)) begin errors++; $display("FAIL restart_fd p=%0d got=%b exp=%b", pos, frame_done, pos == 16); end
        end
        load = 1'b0;
        // Drop enable exactly in the wrap cycle: no frame_done, no commit.
        enable = 1'b0; tick();
        checks += 3;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL bdrop_fd got=%b exp=0", frame_done); end
        if (load_ack !== 1'b0) begin errors++; $display("FAIL bdrop_ack got=%b exp=0", load_ack); end
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL bdrop_valid got=%b exp=0", digit_valid); end
        enable = 1'b1; tick(); pos = 0;
        checks += 3;
        if (load_ack !== 1'b1) begin errors++; $display("FAIL bdrop_reentry_ack got=%b exp=1", load_ack); end
        if (nibble !== 4'h0) begin errors++; $display("FAIL bdrop_reentry_nibble got=%h exp=0", nibble); end
        if (digit_valid !== 1'b1) begin errors++; $display("FAIL bdrop_reentry_valid got=%b exp=1", digit_valid); end
    endtask

    task automatic test_lz_blank();
        logic [15:0] sh;
        while (pos < 32) begin
            if (pos == 5) begin load = 1'b1; value = 16'h0000; end
            else load = 1'b0;
            tick(); pos++;
            sh = (pos >= 16) ? 16'h0000 : 16'h0050;
            checks += 3;
            if (nibble !== dig(sh, (pos / 4) % 4)) begin errors++; $display("FAIL lz_nibble p=%0d got=%h exp=%h", pos, nibble, dig(sh, (pos / 4) % 4)); end
            if (digit_valid !== exp_valid(sh, (pos / 4) % 4)) begin errors++; $display("FAIL lz_valid p=%0d got=%b exp=%b", pos, digit_valid, exp_valid(sh, (pos / 4) % 4)); end
            if (load_ack !== (pos == 16)) begin errors++; $display("FAIL lz_ack p=%0d got=%b exp=%b", pos, load_ack, pos == 16); end
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = 16'h0000;
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_boundary_collision();
        test_enable_drop();
        test_lz_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
